// File: rtl/dff_pipe_chain.sv
// ---------------------------------------------------------------------------
// dff_pipe_chain
//
// A chain of DEPTH elastic register stages with a valid/ready handshake. It
// cuts timing paths between datapath blocks, such as an RX shifter feeding a
// bus read path, and still moves one beat per cycle under back-pressure.
// Every stage has a programmable reset value. A synchronous flush drops all
// held beats.
//
// Parameters
//   DW       data width per stage (>= 1)
//   DEPTH    number of register stages (>= 1)
//   RST_VAL  reset value of every stage's data register
//
// Ports
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   flush    synchronous flush: clears every valid bit, keeps data
//   s_valid  upstream beat valid
//   s_ready  the chain accepts s_data this cycle
//   s_data   upstream data
//   m_valid  output beat valid
//   m_ready  downstream accepts m_data this cycle
//   m_data   data of the last stage
//   occ      held-beat count, 0..DEPTH (present only with DFF_PIPE_OCC_EN)
//
// Optional feature macro: DFF_PIPE_OCC_EN adds the occ port and its counter.
// ---------------------------------------------------------------------------
module dff_pipe_chain #(
    parameter int              DW      = 32,
    parameter int              DEPTH   = 2,
    parameter logic [DW-1:0]   RST_VAL = {DW{1'b1}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DW-1:0]                s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DW-1:0]                m_data
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   occ
`endif
);

    // Stage state: index 0 is the input end, DEPTH-1 the output end.
    logic [DEPTH-1:0]          v_reg;
    logic [DEPTH-1:0]          v_next;
    logic [DEPTH-1:0][DW-1:0]  d_reg;

    logic [DEPTH-1:0]          rdy;       // stage can take a beat this cycle
    logic [DEPTH-1:0]          down_rdy;  // whatever sits downstream of the stage is ready
    logic [DEPTH-1:0]          up_valid;  // the stage's upstream offers a beat
    logic [DEPTH-1:0]          load;      // the stage captures its upstream beat
    logic [DEPTH-1:0][DW-1:0]  up_data;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == DEPTH - 1) begin : g_last
                assign down_rdy[gi] = m_ready;
            end else begin : g_mid
                assign down_rdy[gi] = rdy[gi+1];
            end

            if (gi == 0) begin : g_first
                // A flush cycle never accepts a new beat.
                assign up_valid[gi] = s_valid & ~flush;
                assign up_data[gi]  = s_data;
            end else begin : g_inner
                assign up_valid[gi] = v_reg[gi-1];
                assign up_data[gi]  = d_reg[gi-1];
            end

            // The ready chain ripples back from the output. A full chain
            // therefore still accepts a beat in any cycle the output drains.
            assign rdy[gi]  = ~v_reg[gi] | down_rdy[gi];
            assign load[gi] = rdy[gi] & up_valid[gi];

            // The flush wins over everything else. Otherwise a load sets the
            // valid bit, an outgoing beat with nothing behind it clears it,
            // and a stalled stage holds.
            always_comb begin
                v_next[gi] = v_reg[gi];
                if (flush) begin
                    v_next[gi] = 1'b0;
                end else if (load[gi]) begin
                    v_next[gi] = 1'b1;
                end else if (v_reg[gi] && down_rdy[gi]) begin
                    v_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    // Data registers change only on a load. An emptying transfer or a flush
    // leaves the last value in place, so a stage that is not loading keeps a
    // stable, non-toggling value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_reg <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_reg[k] <= RST_VAL;
            end
        end else begin
            v_reg <= v_next;
            for (int k = 0; k < DEPTH; k++) begin
                if (load[k] && !flush) begin
                    d_reg[k] <= up_data[k];
                end
            end
        end
    end

    assign s_ready = rdy[0] & ~flush;
    assign m_valid = v_reg[DEPTH-1];
    assign m_data  = d_reg[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ_reg;
    logic             accept;
    logic             emit;

    assign accept = s_valid & s_ready;
    assign emit   = m_valid & m_ready;

    // This counter tracks popcount(v_reg) without an adder tree. A flush
    // empties the whole chain, so a delivery in the same cycle needs no
    // separate handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg <= '0;
        end else if (flush) begin
            occ_reg <= '0;
        end else if (accept && !emit) begin
            occ_reg <= occ_reg + OCC_W'(1);
        end else if (emit && !accept) begin
            occ_reg <= occ_reg - OCC_W'(1);
        end
    end

    assign occ = occ_reg;
`endif

endmodule

// File: tb/tb_dff_pipe_chain.sv
// ---------------------------------------------------------------------------
// tb_dff_pipe_chain
//
// Bench for dff_pipe_chain. Instance a uses DW=8 and DEPTH=2 and runs the
// directed tests and the random tests. Instance b uses DW=8 and DEPTH=3 and
// runs the back-to-back streaming test. For each instance, a negedge monitor
// pushes every accepted beat into a queue. It pops and compares on every
// delivered beat and drops the queue on a flush or a reset.
// The occ checks follow DFF_PIPE_OCC_EN.
// ---------------------------------------------------------------------------
module tb_dff_pipe_chain;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       flush = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;

    logic       b_flush = 1'b0;
    logic       b_s_valid = 1'b0;
    logic       b_s_ready;
    logic [7:0] b_s_data = 8'h00;
    logic       b_m_valid;
    logic       b_m_ready = 1'b0;
    logic [7:0] b_m_data;

`ifdef DFF_PIPE_OCC_EN
    logic [1:0] occ;
    logic [1:0] b_occ;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    dff_pipe_chain #(.DW(8), .DEPTH(2), .RST_VAL(8'hFF)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
`ifdef DFF_PIPE_OCC_EN
        ,
        .occ     (occ)
`endif
    );

    dff_pipe_chain #(.DW(8), .DEPTH(3), .RST_VAL(8'hFF)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (b_flush),
        .s_valid (b_s_valid),
        .s_ready (b_s_ready),
        .s_data  (b_s_data),
        .m_valid (b_m_valid),
        .m_ready (b_m_ready),
        .m_data  (b_m_data)
`ifdef DFF_PIPE_OCC_EN
        ,
        .occ     (b_occ)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard for instance a ----------------
    logic       a_prev_stall = 1'b0;
    logic [7:0] a_prev_data  = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            a_prev_stall = 1'b0;
        end else begin
`ifdef DFF_PIPE_OCC_EN
            check("a_occ", 32'(occ), 32'(qa.size()));
`endif
            // A stalled beat must still be there, unchanged, one cycle later.
            if (a_prev_stall) begin
                check("a_stall_valid", 32'(m_valid), 32'd1);
                check("a_stall_data", 32'(m_data), 32'(a_prev_data));
            end
            a_prev_stall = m_valid && !m_ready && !flush;
            a_prev_data  = m_data;

            if (m_valid && m_ready) begin
                $display("a: beat %02h delivered", m_data);
                if (qa.size() == 0) check("a_spurious_beat", 32'(m_data), 32'hDEAD);
                else check("a_data", 32'(m_data), 32'(qa.pop_front()));
            end
            if (flush) qa.delete();
            else if (s_valid && s_ready) qa.push_back(s_data);
        end
    end

    // ---------------- scoreboard for instance b ----------------
    int neg_cnt = 0;
    int b_first_acc = -1;
    int b_first_emit = -1;
    int b_last_emit = -1;
    int b_emits = 0;

    always @(negedge clk) begin
        neg_cnt++;
        if (!rst_n) begin
            qb.delete();
        end else begin
            if (b_m_valid && b_m_ready) begin
                $display("b: beat %02h delivered", b_m_data);
                if (b_first_emit < 0) b_first_emit = neg_cnt;
                b_last_emit = neg_cnt;
                b_emits++;
                if (qb.size() == 0) check("b_spurious_beat", 32'(b_m_data), 32'hDEAD);
                else check("b_data", 32'(b_m_data), 32'(qb.pop_front()));
            end
            if (b_s_valid && b_s_ready) begin
                if (b_first_acc < 0) b_first_acc = neg_cnt;
                qb.push_back(b_s_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // 1. Reset state.
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'hFF);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        check("rel_m_valid", 32'(m_valid), 32'd0);
        check("rel_m_data", 32'(m_data), 32'hFF);
        check("rel_s_ready", 32'(s_ready), 32'd1);
`ifdef DFF_PIPE_OCC_EN
        check("rel_occ", 32'(occ), 32'd0);
`endif

        // 2. DEPTH=3, back-to-back stream 0x01..0x10.
        b_m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            b_s_valid = 1'b1;
            b_s_data  = 8'(i);
            tick();
        end
        b_s_valid = 1'b0;
        repeat (6) tick();
        // The negedge that samples the first accept is 3 negedges (DEPTH)
        // before the negedge that first sees m_valid, which is 2 edges after the accepting edge.
        check("b_latency", 32'(b_first_emit - b_first_acc), 32'd3);
        check("b_count", 32'(b_emits), 32'd16);
        check("b_no_gap", 32'(b_last_emit - b_first_emit), 32'd15);

        // 3. Back-pressure: fill with A1,A2, offer A3.
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'hA1; tick();
        s_data = 8'hA2; tick();
        s_data = 8'hA3;
        check("t3_s_ready_full", 32'(s_ready), 32'd0);
        check("t3_m_data", 32'(m_data), 32'hA1);
        tick();
        check("t3_m_data_held", 32'(m_data), 32'hA1);
`ifdef DFF_PIPE_OCC_EN
        check("t3_occ_2a", 32'(occ), 32'd2);
`endif
        m_ready = 1'b1;
        #1;
        check("t3_s_ready_open", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        check("t3_m_data_a2", 32'(m_data), 32'hA2);
`ifdef DFF_PIPE_OCC_EN
        check("t3_occ_2b", 32'(occ), 32'd2);
`endif
        tick();
        check("t3_m_data_a3", 32'(m_data), 32'hA3);
`ifdef DFF_PIPE_OCC_EN
        check("t3_occ_1", 32'(occ), 32'd1);
`endif
        tick();
        check("t3_empty", 32'(m_valid), 32'd0);
`ifdef DFF_PIPE_OCC_EN
        check("t3_occ_0", 32'(occ), 32'd0);
`endif

        // 4. Full chain streaming at full rate.
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'hB0; tick();
        s_data = 8'hB1; tick();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = 8'(8'hC0 + i);
            #1;
            check("t4_s_ready", 32'(s_ready), 32'd1);
            check("t4_m_valid", 32'(m_valid), 32'd1);
            tick();
`ifdef DFF_PIPE_OCC_EN
            check("t4_occ", 32'(occ), 32'd2);
`endif
        end
        s_valid = 1'b0;
        repeat (3) tick();

        // 5. Flush with two beats held and 0x55 offered.
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'hD1; tick();
        s_data = 8'hD2; tick();
        m_ready = 1'b1;
        flush = 1'b1; s_data = 8'h55;
        #1;
        check("t5_s_ready_flush", 32'(s_ready), 32'd0);
        tick();
        flush = 1'b0; s_valid = 1'b0;
        check("t5_m_valid", 32'(m_valid), 32'd0);
`ifdef DFF_PIPE_OCC_EN
        check("t5_occ", 32'(occ), 32'd0);
`endif
        s_valid = 1'b1; s_data = 8'h66; tick();
        s_valid = 1'b0;
        check("t5_push_lat1", 32'(m_valid), 32'd0);
        tick();
        check("t5_push_valid", 32'(m_valid), 32'd1);
        check("t5_push_data", 32'(m_data), 32'h66);
        repeat (2) tick();

        // 6. Asynchronous reset while a beat is stalled.
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'hE1; tick();
        s_valid = 1'b0; tick();
        check("t6_held", 32'(m_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(m_valid), 32'd0);
        check("t6_async_data", 32'(m_data), 32'hFF);
        tick();
        rst_n = 1'b1;
        tick();

        // Random valid/ready/flush traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 31) == 0);
            tick();
        end
        s_valid = 1'b0; flush = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 10 && qa.size() != 0; i++) tick();
        tick();
        check("rand_drained", 32'(qa.size()), 32'd0);
        check("rand_m_valid_idle", 32'(m_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
